// File: rtl/mem_load_pkg.sv
// rtl/mem_load_pkg.sv - shared encodings, states and alignment check for mem_load_unit
package mem_load_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } load_size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    EXTRACT = 2'b10,
    FAULT   = 2'b11
  } state_e;

  localparam int MAX_MEM_LATENCY = 15;

  // Reserved size is treated as misaligned so it takes the fault path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_WORD: return (addr_lo != 2'b00);
      SIZE_HALF: return addr_lo[0];
      SIZE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - combinational lane select and extension of the MDR word
// LOAD_SIGNED_EN enables sign extension; otherwise all sub-word loads zero-extend.
module load_extract
  import mem_load_pkg::*;
(
  input  logic [31:0] mdr,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
`ifdef LOAD_SIGNED_EN
  input  logic        load_signed,
`endif
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  always_comb begin
    byte_sel = mdr[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mdr[31:16] : mdr[15:0];
    fill     = 1'b0;
    ext_data = mdr;
    case (size)
      SIZE_HALF: begin
`ifdef LOAD_SIGNED_EN
        fill = load_signed & half_sel[15];
`endif
        ext_data = {{16{fill}}, half_sel};
      end
      SIZE_BYTE: begin
`ifdef LOAD_SIGNED_EN
        fill = load_signed & byte_sel[7];
`endif
        ext_data = {{24{fill}}, byte_sel};
      end
      default: ext_data = mdr;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - load FSM: latency counter, MDR capture and registered extended result
// LOAD_SIGNED_EN keeps the latched LoadSigned flop and honours sign extension.
module mem_load_unit
  import mem_load_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  LoadSize,
  input  logic        LoadSigned,
  input  logic [1:0]  AddrLo,
  input  logic [31:0] MemData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] LoadData
);

  localparam int LAT_CLAMP = (MEM_LATENCY < 1) ? 1 :
                             (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;
  localparam logic [3:0] CNT_LOAD = 4'(LAT_CLAMP - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mdr_q, mdr_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] load_data_q, load_data_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] ext_data;

`ifdef LOAD_SIGNED_EN
  logic        signed_q, signed_d;
`else
  logic        unused_load_signed;
  assign unused_load_signed = LoadSigned;
`endif

  load_extract u_extract (
    .mdr         (mdr_q),
    .size        (size_q),
    .addr_lo     (addr_q),
`ifdef LOAD_SIGNED_EN
    .load_signed (signed_q),
`endif
    .ext_data    (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdr_d       = mdr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
`ifdef LOAD_SIGNED_EN
    signed_d    = signed_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          size_d = LoadSize;
          addr_d = AddrLo;
`ifdef LOAD_SIGNED_EN
          signed_d = LoadSigned;
`endif
          if (is_misaligned(LoadSize, AddrLo)) begin
            state_d = FAULT;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          mdr_d   = MemData;
          state_d = EXTRACT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EXTRACT: begin
        load_data_d = ext_data;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      FAULT: begin
        done_d  = 1'b1;
        fault_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mdr_q       <= 32'd0;
      size_q      <= 2'b00;
      addr_q      <= 2'b00;
      load_data_q <= 32'd0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
`ifdef LOAD_SIGNED_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdr_q       <= mdr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      load_data_q <= load_data_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
`ifdef LOAD_SIGNED_EN
      signed_q    <= signed_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign fault    = fault_q;
  assign LoadData = load_data_q;

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Memory read-side counterpart to the store-data path of the multi-cycle MIPS datapath. On a one-cycle start pulse from the control unit, the unit waits a fixed memory latency, captures the memory word, and selects the addressed byte, halfword or word. It then extends the result to 32 bits and presents it on a registered output for the register-file write-back mux, with a one-cycle done pulse for the control FSM.

## Interface
- MEM_LATENCY, 1: cycles from start to valid MemData; legal 1..15
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle load request; ignored while busy
- LoadSize  in  2  00 word, 01 halfword, 10 byte, 11 reserved
- LoadSigned  in  1  1 = sign-extend, 0 = zero-extend
- AddrLo  in  2  byte offset (address bits [1:0])
- MemData  in  32  memory read data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle pulse coincident with done on a misaligned or reserved request
- LoadData  out  32  extended load result, registered

## Operation
- States: IDLE, WAIT, EXTRACT, FAULT.
- IDLE + start:
  - Latch LoadSize, LoadSigned and AddrLo.
  - If the request is misaligned, go to FAULT. Misaligned means word with AddrLo≠00, halfword with AddrLo[0]=1, or LoadSize=11.
  - Otherwise load the 4-bit counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, register MemData into the internal MDR and go to EXTRACT.
- EXTRACT:
  - Update LoadData from the MDR and pulse done. Go to IDLE.
  - Lanes are little-endian.
    - Byte: offset 0 = [7:0], 1 = [15:8], 2 = [23:16], 3 = [31:24].
    - Halfword: offset 0 = [15:0], 2 = [31:16].
  - Extension: replicate the MSB of the selected field when LoadSigned=1, else fill with zeros.
- FAULT: pulse done and fault together. LoadData holds its previous value. Go to IDLE.
- start while not in IDLE is ignored; no queuing.
- start in the same cycle the unit returns to IDLE is not possible, because done is issued from EXTRACT/FAULT. start is accepted in the cycle after done.
- Reset mid-operation: return to IDLE immediately and abandon the request. No done is issued.

## Timing
- Reset values: busy=0, done=0, fault=0, LoadData=0, MDR=0, counter=0, state=IDLE.
- start sampled high at edge 0:
  - busy is high from edge 0 through edge MEM_LATENCY+1 exclusive.
  - MemData is sampled at edge MEM_LATENCY.
  - done and the new LoadData are visible after edge MEM_LATENCY+1.
  - Load latency is MEM_LATENCY+1 cycles.
- Fault path: done and fault are high for the cycle after edge 1. Latency is 1 cycle.
- LoadData changes only on the edge that raises a non-fault done, and holds until the next one.
- MemData only needs to be stable at the sampling edge.

## Configuration
- LOAD_SIGNED_EN defined: LoadSigned is honoured as described.
- LOAD_SIGNED_EN undefined:
  - LoadSigned is ignored and all byte/halfword loads zero-extend.
  - Extension logic and the latched LoadSigned flop are removed.
  - fault rules are unchanged.

## Structure
- Shared package mem_load_pkg:
  - LoadSize encodings: SIZE_WORD, SIZE_HALF, SIZE_BYTE, SIZE_RSVD.
  - State enum: IDLE, WAIT, EXTRACT, FAULT.
  - Constant MAX_MEM_LATENCY = 15.
- Sub-module load_extract: purely combinational.
  - Inputs: MDR, latched LoadSize, latched AddrLo, latched LoadSigned.
  - Output: the 32-bit extended value.
  - The top level holds the FSM, counter, MDR and output registers.

## Test plan
- MEM_LATENCY=2; word load, AddrLo=00, MemData=0xDEADBEEF → done 3 cycles after start, LoadData=0xDEADBEEF, fault=0.
- Byte load, AddrLo=11, LoadSigned=1, MemData=0x80112233 → LoadData=0xFFFFFF80. Same request with LoadSigned=0 → 0x00000080. With LOAD_SIGNED_EN undefined, 0x00000080 in both cases.
- Halfword load, AddrLo=10, LoadSigned=1, MemData=0x7FFF8000 → LoadData=0x00007FFF. With AddrLo=00 → 0xFFFF8000.
- Halfword load with AddrLo=01 → done and fault high 1 cycle after start, LoadData unchanged, MemData never sampled. LoadSize=11 → same response.
- Second start pulsed during WAIT → ignored: exactly one done, result from the first request.
- Reset asserted during WAIT → busy=0, LoadData=0 immediately, no done. A fresh start after release completes normally.
